stepper_sequencer: RTL and testbench

//  Parametrised successor to the 4-coil stepper driver. Adds wave, two-phase and half-step modes,
//  a programmable step-rate divider, counted moves with a valid/ready command handshake, and abort.

---
 rtl/stepper_sequencer.sv | 176 +++++++++++++++++
 tb/tb_stepper_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_sequencer.sv
// Four-coil stepper sequencer: wave / two-phase / half-step patterns, a
// programmable step-rate divider, counted moves taken through a valid/ready
// command port, abort, absolute position tracking and idle hold/release.
module stepper_sequencer #(
    parameter int DIV_W       = 16,
    parameter int CNT_W       = 16,
    parameter int POS_W       = 24,
    parameter bit COIL_ACTIVE = 1'b1
) (
    input  logic             system1000,
    input  logic             system1000_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [1:0]       cmd_mode,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic             abort,
    input  logic             hold,
    output logic [3:0]       coils,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [POS_W-1:0] position
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [2:0]       idx;
    logic [POS_W-1:0] pos;
    logic [CNT_W-1:0] remaining;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] period_q;
    logic [DIV_W-1:0] last_div;
    logic             dir_q;
    logic [1:0]       mode_q;
    logic             aborted_q;

    logic             accept;
    logic             step;
    logic [2:0]       mag;
    logic [3:0]       pattern;
    logic [3:0]       coil_on;

    // Command handshake: a command transfers on a rising edge where
    // cmd_valid && cmd_ready are both high. cmd_ready is high only in IDLE and
    // never during reset; the command fields are captured on that same edge
    // and held for the whole move, so the source may change them afterwards.
    assign cmd_ready = (state == IDLE) && !system1000_rst;
    assign accept    = cmd_valid && cmd_ready;

    // A period of 0 runs at one step per clock, same as a period of 1.
    assign last_div = (period_q == '0) ? '0 : period_q - 1'b1;

    // Abort wins over a step that would land on the same edge.
    assign step = (state == RUN) && !abort && (div == last_div);

    // Half-step walks the table one entry at a time, full modes two.
    assign mag = (mode_q == 2'b10) ? 3'd1 : 3'd2;

    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign aborted  = (state == DONE) && aborted_q;
    assign position = pos;

    function automatic logic [3:0] phase_table(input logic [2:0] i);
        case (i)
            3'd0:    phase_table = 4'b1000;
            3'd1:    phase_table = 4'b1100;
            3'd2:    phase_table = 4'b0100;
            3'd3:    phase_table = 4'b0110;
            3'd4:    phase_table = 4'b0010;
            3'd5:    phase_table = 4'b0011;
            3'd6:    phase_table = 4'b0001;
            default: phase_table = 4'b1001;
        endcase
    endfunction

    // Map the shared phase index onto the pattern of the active mode.
    always_comb begin
        pattern = phase_table(idx);
        case (mode_q)
            2'b00:   pattern = phase_table(idx & 3'b110);
            2'b10:   pattern = phase_table(idx);
            default: pattern = phase_table(idx | 3'b001);
        endcase
        coil_on = pattern;
        if (state == IDLE && !hold) begin
            coil_on = 4'b0000;
        end
    end

    // Next-state logic for the move sequencer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (cmd_steps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = DONE;
                end else if (step && remaining == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command capture, rate divider, step counter, phase index and position.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            idx       <= 3'd0;
            pos       <= '0;
            remaining <= '0;
            div       <= '0;
            period_q  <= '0;
            dir_q     <= 1'b0;
            mode_q    <= 2'b00;
            aborted_q <= 1'b0;
        end else if (accept) begin
            dir_q     <= cmd_dir;
            mode_q    <= cmd_mode;
            period_q  <= cmd_period;
            remaining <= cmd_steps;
            div       <= '0;
            aborted_q <= 1'b0;
        end else if (state == RUN) begin
            if (abort) begin
                aborted_q <= 1'b1;
            end else if (step) begin
                div       <= '0;
                remaining <= remaining - 1'b1;
                if (dir_q) begin
                    idx <= idx + mag;
                    pos <= pos + POS_W'(mag);
                end else begin
                    idx <= idx - mag;
                    pos <= pos - POS_W'(mag);
                end
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    // Registered coil drive with output polarity applied.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            coils <= {4{~COIL_ACTIVE}};
        end else begin
            coils <= COIL_ACTIVE ? coil_on : ~coil_on;
        end
    end

endmodule

// File: tb/tb_stepper_sequencer.sv
// Bench for stepper_sequencer: a normal-polarity and an inverted-polarity
// instance share every input; a reference model predicts coil patterns,
// move latency and end-of-move position/abort status.
module tb_stepper_sequencer;

    localparam int DIV_W = 16;
    localparam int CNT_W = 16;
    localparam int POS_W = 24;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_dir = 1'b0;
    logic [CNT_W-1:0] cmd_steps = '0;
    logic [1:0]       cmd_mode = 2'b00;
    logic [DIV_W-1:0] cmd_period = '0;
    logic             abort = 1'b0;
    logic             hold = 1'b1;

    logic             cmd_ready, busy, done, aborted;
    logic [3:0]       coils;
    logic [POS_W-1:0] position;
    logic             cmd_ready_i, busy_i, done_i, aborted_i;
    logic [3:0]       coils_i;
    logic [POS_W-1:0] position_i;

    stepper_sequencer #(.DIV_W(DIV_W), .CNT_W(CNT_W), .POS_W(POS_W), .COIL_ACTIVE(1'b1)) dut (
        .system1000(clk), .system1000_rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_mode(cmd_mode), .cmd_period(cmd_period),
        .abort(abort), .hold(hold), .coils(coils), .busy(busy), .done(done),
        .aborted(aborted), .position(position)
    );

    stepper_sequencer #(.DIV_W(DIV_W), .CNT_W(CNT_W), .POS_W(POS_W), .COIL_ACTIVE(1'b0)) dut_inv (
        .system1000(clk), .system1000_rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_i),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_mode(cmd_mode), .cmd_period(cmd_period),
        .abort(abort), .hold(hold), .coils(coils_i), .busy(busy_i), .done(done_i),
        .aborted(aborted_i), .position(position_i)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard queues
    logic [3:0]     exp_q[$];
    logic [POS_W:0] exp_done_q[$];
    logic           mon_en = 1'b0;
    logic [3:0]     last_coils = 4'b0000;
    logic [3:0]     e_coils;
    logic [POS_W:0] e_done;

    // Reference model state
    logic [2:0]       m_idx  = 3'd0;
    logic [POS_W-1:0] m_pos  = '0;
    logic [1:0]       m_mode = 2'b00;
    logic [3:0]       m_disp = 4'b1000;

    function automatic logic [3:0] ref_phase(input logic [2:0] i);
        logic [3:0] t;
        case (i)
            3'd0: t = 4'b1000;
            3'd1: t = 4'b1100;
            3'd2: t = 4'b0100;
            3'd3: t = 4'b0110;
            3'd4: t = 4'b0010;
            3'd5: t = 4'b0011;
            3'd6: t = 4'b0001;
            default: t = 4'b1001;
        endcase
        return t;
    endfunction

    function automatic logic [3:0] ref_shown(input logic [2:0] i, input logic [1:0] m);
        if (m == 2'b00) return ref_phase({i[2:1], 1'b0});
        if (m == 2'b10) return ref_phase(i);
        return ref_phase({i[2:1], 1'b1});
    endfunction

    // Monitor: every coil change pops the coil queue; every done pulse pops the done queue.
    always @(negedge clk) begin
        if (mon_en && coils !== last_coils) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL coils_unexpected: got %b, nothing expected", coils);
            end else begin
                e_coils = exp_q.pop_front();
                if (coils !== e_coils) begin
                    n_fail++; $display("FAIL coils_seq: got %b, expected %b", coils, e_coils);
                end
            end
            n_checks++;
            if (coils_i !== ~coils || position_i !== position) begin
                n_fail++; $display("FAIL coils_inverted: got %b pos %0d, expected %b pos %0d", coils_i, position_i, ~coils, position);
            end
            last_coils = coils;
        end
        if (done === 1'b1) begin
            n_checks++;
            if (exp_done_q.size() == 0) begin
                n_fail++; $display("FAIL done_unexpected: got done=1, expected no done");
            end else begin
                e_done = exp_done_q.pop_front();
                if ({aborted, position} !== e_done || busy !== 1'b0) begin
                    n_fail++; $display("FAIL done_status: got aborted=%b pos=%h busy=%b, expected aborted=%b pos=%h busy=0", aborted, position, busy, e_done[POS_W], e_done[POS_W-1:0]);
                end
            end
        end
    end

    task automatic push_coils(input logic [3:0] p);
        if (p != m_disp) begin
            exp_q.push_back(p);
            m_disp = p;
        end
    endtask

    // Driver: one move, with its expectations pushed before it is issued.
    task automatic run_move(input logic dir, input int steps, input logic [1:0] mode,
                            input int period, input int abort_at);
        int p, taken, exp_k, k, wait_n;
        logic ab;
        logic [2:0] mg;
        p = (period == 0) ? 1 : period;
        if (abort_at > 0 && abort_at <= steps * p) begin
            ab = 1'b1; taken = (abort_at - 1) / p; exp_k = abort_at;
        end else begin
            ab = 1'b0; taken = steps; exp_k = steps * p;
        end
        m_mode = mode;
        mg = (mode == 2'b10) ? 3'd1 : 3'd2;
        push_coils(ref_shown(m_idx, m_mode));
        for (int i = 0; i < taken; i++) begin
            if (dir) begin
                m_idx = m_idx + mg; m_pos = m_pos + POS_W'(mg);
            end else begin
                m_idx = m_idx - mg; m_pos = m_pos - POS_W'(mg);
            end
            push_coils(ref_shown(m_idx, m_mode));
        end
        if (!hold) push_coils(4'b0000);
        exp_done_q.push_back({ab, m_pos});

        @(negedge clk);
        wait_n = 0;
        while (cmd_ready !== 1'b1 && wait_n < 50) begin
            @(negedge clk); wait_n++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_timeout: got cmd_ready=%b, expected 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_dir = dir; cmd_steps = CNT_W'(steps);
        cmd_mode = mode; cmd_period = DIV_W'(period);
        @(posedge clk);
        for (k = 0; k < exp_k + 20; k++) begin
            @(negedge clk);
            if (k == 0) begin
                cmd_valid = 1'b0;
                cmd_steps = CNT_W'($urandom_range(0, 65535));
                cmd_period = DIV_W'($urandom_range(0, 65535));
                n_checks++;
                if (busy !== (steps != 0)) begin
                    n_fail++; $display("FAIL busy_after_accept: got %b, expected %b", busy, steps != 0);
                end
            end
            if (done === 1'b1) break;
            abort = ab && (k + 1 == abort_at);
        end
        abort = 1'b0;
        n_checks++;
        if (k != exp_k) begin
            n_fail++; $display("FAIL done_latency: got %0d edges, expected %0d", k, exp_k);
        end
        n_checks++;
        if (position !== m_pos) begin
            n_fail++; $display("FAIL position: got %h, expected %h", position, m_pos);
        end
    endtask

    task automatic model_reset();
        m_idx = 3'd0; m_pos = '0; m_mode = 2'b00; m_disp = 4'b1000;
        exp_q.delete();
        last_coils = coils;
    endtask

    task automatic test_reset();
        hold = 1'b1; rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (coils !== 4'b0000 || coils_i !== 4'b1111) begin
            n_fail++; $display("FAIL reset_coils: got %b/%b, expected 0000/1111", coils, coils_i);
        end
        n_checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 || position !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got ready=%b busy=%b done=%b ab=%b pos=%h, expected 0 0 0 0 0", cmd_ready, busy, done, aborted, position);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (coils !== 4'b1000 || coils_i !== 4'b0111 || cmd_ready !== 1'b1 || position !== '0) begin
            n_fail++; $display("FAIL post_reset: got coils=%b inv=%b ready=%b pos=%h, expected 1000 0111 1 0", coils, coils_i, cmd_ready, position);
        end
        model_reset();
        mon_en = 1'b1;
    endtask

    task automatic test_two_phase_rev();
        run_move(1'b0, 2, 2'b01, 1, 0);
        n_checks++;
        if (position !== {{(POS_W-3){1'b1}}, 3'b100}) begin
            n_fail++; $display("FAIL two_phase_wrap: got %h, expected fffffc", position);
        end
    endtask

    task automatic test_half_fwd();
        run_move(1'b1, 3, 2'b10, 2, 0);
    endtask

    task automatic test_abort();
        run_move(1'b1, 1000, 2'b00, 4, 10);
    endtask

    task automatic test_null_move();
        run_move(1'b1, 0, 2'b00, 3, 0);
    endtask

    task automatic test_period_zero();
        run_move(1'b0, 3, 2'b10, 0, 0);
    endtask

    task automatic test_idle_abort();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (position !== m_pos || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL idle_abort: got pos=%h busy=%b ready=%b, expected pos=%h busy=0 ready=1", position, busy, cmd_ready, m_pos);
        end
    endtask

    task automatic test_hold_release();
        @(negedge clk);
        hold = 1'b0;
        push_coils(4'b0000);
        repeat (3) @(negedge clk);
        n_checks++;
        if (coils !== 4'b0000 || coils_i !== 4'b1111) begin
            n_fail++; $display("FAIL hold_release: got %b/%b, expected 0000/1111", coils, coils_i);
        end
        run_move(1'b1, 2, 2'b10, 1, 0);
        repeat (3) @(negedge clk);
        hold = 1'b1;
        push_coils(ref_shown(m_idx, m_mode));
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            run_move(1'($urandom_range(0, 1)), $urandom_range(0, 5), 2'($urandom_range(0, 3)),
                     $urandom_range(0, 3), 0);
        end
    endtask

    task automatic test_reset_mid_move();
        mon_en = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = CNT_W'(100);
        cmd_mode = 2'b10; cmd_period = DIV_W'(2);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || position !== m_pos + POS_W'(3)) begin
            n_fail++; $display("FAIL mid_move: got busy=%b pos=%h, expected busy=1 pos=%h", busy, position, m_pos + POS_W'(3));
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || coils !== 4'b0000 || position !== '0 || cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_move: got busy=%b done=%b coils=%b pos=%h ready=%b, expected 0 0 0000 0 0", busy, done, coils, position, cmd_ready);
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (coils !== 4'b1000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL after_reset_mid_move: got coils=%b busy=%b, expected 1000 0", coils, busy);
        end
        model_reset();
        mon_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_two_phase_rev();
        test_half_fwd();
        test_abort();
        test_null_move();
        test_period_zero();
        test_idle_abort();
        test_hold_release();
        test_back_to_back();
        test_reset_mid_move();
        run_move(1'b1, 2, 2'b01, 2, 0);
        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || exp_done_q.size() != 0) begin
            n_fail++; $display("FAIL queues_drained: got %0d coil and %0d done entries left, expected 0 and 0", exp_q.size(), exp_done_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
